// File: rtl/if_stage_if.sv
// if_stage_if: groups the signals of the instruction-fetch stage into one bundle.
//   master modport : used by if_stage (drives the PC, IF/ID register and status)
//   slave modport  : used by the surroundings (ROM, hazard unit, EX redirect)
// Signals:
//   instr_addr   word-aligned PC presented to the instruction ROM
//   instruction  ROM word at instr_addr (combinational)
//   stall        hold PC and IF/ID
//   flush        load a bubble into IF/ID
//   redirect     taken branch/jump from EX, target in redirect_pc
//   if_id_*      IF/ID pipeline register contents
//   halted       fetch FSM is in HALT
//   misalign_err sticky flag: a redirect target had nonzero low bits
//   fetch_count  number of valid instructions captured into IF/ID
interface if_stage_if;
  logic [31:0] instr_addr;
  logic [31:0] instruction;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_count;

  modport master (
    output instr_addr,
    input  instruction,
    input  stall,
    input  flush,
    input  redirect,
    input  redirect_pc,
    output if_id_pc,
    output if_id_pc4,
    output if_id_instr,
    output if_id_valid,
    output halted,
    output misalign_err,
    output fetch_count
  );

  modport slave (
    input  instr_addr,
    output instruction,
    output stall,
    output flush,
    output redirect,
    output redirect_pc,
    input  if_id_pc,
    input  if_id_pc4,
    input  if_id_instr,
    input  if_id_valid,
    input  halted,
    input  misalign_err,
    input  fetch_count
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage RV32I pipeline.
// Owns the PC, fetches from a combinational ROM and registers the word into
// the IF/ID pipeline register. Applies redirect > stall > flush > normal, and
// stops fetching (RUN -> HALT) after capturing ECALL/EBREAK.
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  asynchronous active-high reset
//   bus  if_stage_if.master bundle (ROM, hazard/EX controls, IF/ID, status)
// Parameters:
//   RESET_PC   PC loaded on reset
//   NOP_INSTR  bubble encoding (addi x0,x0,0)
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  if_stage_if.master    bus
);

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] if_id_pc_reg, if_id_pc_next;
  logic [31:0] if_id_pc4_reg, if_id_pc4_next;
  logic [31:0] if_id_instr_reg, if_id_instr_next;
  logic        if_id_valid_reg, if_id_valid_next;
  logic        misalign_reg, misalign_next;
  logic [31:0] fetch_count_reg, fetch_count_next;

  logic [31:0] pc_plus4;
  logic        is_system;

  // 32-bit modulo add: the top word wraps to address 0.
  assign pc_plus4  = pc_reg + 32'd4;
  assign is_system = (bus.instruction == ECALL) || (bus.instruction == EBREAK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= RUN;
      pc_reg          <= RESET_PC;
      if_id_pc_reg    <= 32'd0;
      if_id_pc4_reg   <= 32'd0;
      if_id_instr_reg <= NOP_INSTR;
      if_id_valid_reg <= 1'b0;
      misalign_reg    <= 1'b0;
      fetch_count_reg <= 32'd0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      if_id_pc_reg    <= if_id_pc_next;
      if_id_pc4_reg   <= if_id_pc4_next;
      if_id_instr_reg <= if_id_instr_next;
      if_id_valid_reg <= if_id_valid_next;
      misalign_reg    <= misalign_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  always_comb begin
    // Default: everything holds (this is also the stall behaviour).
    state_next       = state_reg;
    pc_next          = pc_reg;
    if_id_pc_next    = if_id_pc_reg;
    if_id_pc4_next   = if_id_pc4_reg;
    if_id_instr_next = if_id_instr_reg;
    if_id_valid_next = if_id_valid_reg;
    misalign_next    = misalign_reg;
    fetch_count_next = fetch_count_reg;

    if (bus.redirect) begin
      // Target is forced word-aligned; a misaligned request is only flagged.
      pc_next          = {bus.redirect_pc[31:2], 2'b00};
      if_id_instr_next = NOP_INSTR;
      if_id_valid_next = 1'b0;
      state_next       = RUN;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        misalign_next = 1'b1;
      end
    end else if (bus.stall) begin
      // hold
    end else if (bus.flush) begin
      if_id_instr_next = NOP_INSTR;
      if_id_valid_next = 1'b0;
      if (state_reg == RUN) begin
        pc_next = pc_plus4;
      end
    end else if (state_reg == RUN) begin
      if_id_pc_next    = pc_reg;
      if_id_pc4_next   = pc_plus4;
      if_id_instr_next = bus.instruction;
      if_id_valid_next = 1'b1;
      fetch_count_next = fetch_count_reg + 32'd1;
      // ECALL/EBREAK is passed down as a real instruction, then fetch parks.
      if (is_system) begin
        state_next = HALT;
      end else begin
        pc_next = pc_plus4;
      end
    end else begin
      // HALT: keep inserting bubbles with the PC parked.
      if_id_instr_next = NOP_INSTR;
      if_id_valid_next = 1'b0;
    end
  end

  assign bus.instr_addr   = pc_reg;
  assign bus.if_id_pc     = if_id_pc_reg;
  assign bus.if_id_pc4    = if_id_pc4_reg;
  assign bus.if_id_instr  = if_id_instr_reg;
  assign bus.if_id_valid  = if_id_valid_reg;
  assign bus.halted       = (state_reg == HALT);
  assign bus.misalign_err = misalign_reg;
  assign bus.fetch_count  = fetch_count_reg;

endmodule
